probe_checker: RTL and testbench
================================

PROBE_CHECKER -- requirements
Module: probe_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, probe address width.
REQ-002 SHALL have parameter DATA_W, default 32, probed data width.
REQ-003 SHALL have parameter DEPTH, default 64, check-table entries; IW = clog2(DEPTH), CW = clog2(DEPTH+1).
REQ-004 SHALL have parameter SETTLE, default 5000, cycles waited after start before the first probe.
REQ-005 SHALL have parameter LAT, default 1, range 1..15, cycles from probe_addr change to valid probe_data.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 ld_en  in  1  write one table entry this cycle.
REQ-009 ld_idx  in  IW  table index written.
REQ-010 ld_addr  in  ADDR_W  probe address stored.
REQ-011 ld_exp  in  DATA_W  expected value stored.
REQ-012 start  in  1  single-cycle run request.
REQ-013 num  in  CW  entries to check, sampled on start.
REQ-014 probe_addr  out  ADDR_W  address driven to the DUT debug port.
REQ-015 probe_data  in  DATA_W  DUT debug read data.
REQ-016 busy  out  1  run in progress.
REQ-017 done  out  1  held high from run end until next start.
REQ-018 pass_cnt, fail_cnt  out  CW each  result counters.
REQ-019 fail_pulse  out  1  one-cycle pulse per mismatch.
REQ-020 first_fail_idx  out  IW; first_fail_got  out  DATA_W  first mismatch record.

Function
REQ-021 FSM states SHALL be IDLE, SETTLE, ISSUE, WAIT, CHECK, FIN.
REQ-022 IDLE + start: latch num, clear counters/done/first-fail record, idx<=0, settle counter<=0 -> SETTLE.
REQ-023 start with num==0 SHALL go directly to FIN (done next cycle, counters 0).
REQ-024 SETTLE SHALL count SETTLE cycles then -> ISSUE; SETTLE==0 passes through in one cycle.
REQ-025 ISSUE SHALL drive probe_addr <= table[idx].addr, load latency counter with LAT, -> WAIT.
REQ-026 WAIT SHALL decrement latency counter; at 1 -> CHECK; probe_data sampled in CHECK is exactly LAT cycles after probe_addr update.
REQ-027 CHECK SHALL compare probe_data to table[idx].exp over full DATA_W; equal -> pass_cnt+1, else fail_cnt+1 and fail_pulse for one cycle.
REQ-028 first mismatch of a run SHALL capture idx and probe_data; later mismatches SHALL not overwrite.
REQ-029 CHECK: if idx==num-1 -> FIN, else idx+1 -> ISSUE; throughput one entry per LAT+2 cycles.
REQ-030 FIN SHALL set done, clear busy, -> IDLE; results hold until next start.
REQ-031 busy SHALL be high in SETTLE, ISSUE, WAIT, CHECK, FIN-entry cycle excluded.
REQ-032 start while busy SHALL be ignored.
REQ-033 ld_en while busy SHALL be ignored; ld_en in IDLE writes next cycle-visible entry.
REQ-034 num > DEPTH SHALL be clamped to DEPTH.
REQ-035 counters SHALL not wrap (max DEPTH fits CW).
REQ-036 probe_addr SHALL hold its last value in IDLE/FIN.

Reset
REQ-037 rst SHALL force IDLE immediately, including mid-run; run is abandoned without done.
REQ-038 reset values: probe_addr 0, busy 0, done 0, counters 0, fail_pulse 0, first_fail_idx 0, first_fail_got 0.
REQ-039 table contents SHALL not be reset (RAM-inferable).

Structure
REQ-040 state encoding typedef and clog2 helper SHALL live in shared package probe_pkg.
REQ-041 the table SHALL be a sub-module probe_table (1 write port, 1 async read port, DEPTH x (ADDR_W+DATA_W)).

Verification
REQ-042 Load 3 entries {04:5, 08:8, 0C:13}, DUT model returns matching data, SETTLE=10, LAT=1, start -> done, pass_cnt=3, fail_cnt=0, no fail_pulse.
REQ-043 Entry 1 expected 9, DUT returns 8 -> fail_cnt=1, pass_cnt=2, first_fail_idx=1, first_fail_got=8, one fail_pulse.
REQ-044 LAT=3, model delays data 3 cycles -> all pass; LAT=3 with 4-cycle model -> mismatches.
REQ-045 start with num=0 -> done within 2 cycles, counters 0, probe_addr unchanged.
REQ-046 rst asserted during WAIT of entry 2 -> busy, done, counters 0 same cycle; new start reruns cleanly with table intact.
REQ-047 start and ld_en pulsed while busy -> no effect on counters, table, or state sequence.

Source files
------------

// File: rtl/probe_pkg.sv
// Shared definitions for the probe checker: FSM state encoding and a width helper.
package probe_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_FIN
    } state_e;

    // Ceiling log2, never below 1 so derived port widths stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/probe_table.sv
// Check table: one write port, one asynchronous read port, each entry {probe address, expected data}.
module probe_table #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IW     = 6
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [IW-1:0]     wr_idx_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_exp_i,
    input  logic [IW-1:0]     rd_idx_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_exp_o
);

    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i && (int'(wr_idx_i) < DEPTH)) begin
            mem_q[wr_idx_i] <= {wr_addr_i, wr_exp_i};
        end
    end

    assign {rd_addr_o, rd_exp_o} = mem_q[rd_idx_i];

endmodule

// File: rtl/probe_checker.sv
// Walks a table of {address, expected} pairs, drives each address to a debug port,
// waits LAT cycles and compares the returned data, counting passes and failures.
module probe_checker
    import probe_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int SETTLE = 5000,
    parameter int LAT    = 1,
    localparam int IW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [IW-1:0]     ld_idx,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_exp,
    input  logic              start,
    input  logic [CW-1:0]     num,
    output logic [ADDR_W-1:0] probe_addr,
    input  logic [DATA_W-1:0] probe_data,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     pass_cnt,
    output logic [CW-1:0]     fail_cnt,
    output logic              fail_pulse,
    output logic [IW-1:0]     first_fail_idx,
    output logic [DATA_W-1:0] first_fail_got
);

    localparam int SW          = clog2(SETTLE + 1);
    localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     num_q, num_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [3:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] probe_addr_q, probe_addr_d;
    logic              done_q, done_d;
    logic [CW-1:0]     pass_q, pass_d;
    logic [CW-1:0]     fail_q, fail_d;
    logic              fail_pulse_q, fail_pulse_d;
    logic [IW-1:0]     ff_idx_q, ff_idx_d;
    logic [DATA_W-1:0] ff_got_q, ff_got_d;

    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_exp;

    // The table only accepts loads while the checker is parked in IDLE.
    probe_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_table (
        .clk       (clk),
        .wr_en_i   (ld_en && (state_q == S_IDLE)),
        .wr_idx_i  (ld_idx),
        .wr_addr_i (ld_addr),
        .wr_exp_i  (ld_exp),
        .rd_idx_i  (idx_q),
        .rd_addr_o (tbl_addr),
        .rd_exp_o  (tbl_exp)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        num_d        = num_q;
        settle_d     = settle_q;
        lat_d        = lat_q;
        probe_addr_d = probe_addr_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        fail_pulse_d = 1'b0;
        ff_idx_d     = ff_idx_q;
        ff_got_d     = ff_got_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d    = (num > CW'(DEPTH)) ? CW'(DEPTH) : num;
                    pass_d   = '0;
                    fail_d   = '0;
                    done_d   = 1'b0;
                    ff_idx_d = '0;
                    ff_got_d = '0;
                    idx_d    = '0;
                    settle_d = '0;
                    state_d  = (num == '0) ? S_FIN : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_q >= SW'(SETTLE_LAST)) begin
                    state_d = S_ISSUE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_ISSUE: begin
                probe_addr_d = tbl_addr;
                lat_d        = 4'(LAT);
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q <= 4'd1) begin
                    state_d = S_CHECK;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (probe_data == tbl_exp) begin
                    pass_d = pass_q + CW'(1);
                end else begin
                    fail_d       = fail_q + CW'(1);
                    fail_pulse_d = 1'b1;
                    // A zero fail count means this is the first mismatch of the run.
                    if (fail_q == '0) begin
                        ff_idx_d = idx_q;
                        ff_got_d = probe_data;
                    end
                end
                if ((CW'(idx_q) + CW'(1)) >= num_q) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            num_q        <= '0;
            settle_q     <= '0;
            lat_q        <= '0;
            probe_addr_q <= '0;
            done_q       <= 1'b0;
            pass_q       <= '0;
            fail_q       <= '0;
            fail_pulse_q <= 1'b0;
            ff_idx_q     <= '0;
            ff_got_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            num_q        <= num_d;
            settle_q     <= settle_d;
            lat_q        <= lat_d;
            probe_addr_q <= probe_addr_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            fail_pulse_q <= fail_pulse_d;
            ff_idx_q     <= ff_idx_d;
            ff_got_q     <= ff_got_d;
        end
    end

    assign busy           = (state_q == S_SETTLE) || (state_q == S_ISSUE) ||
                            (state_q == S_WAIT)   || (state_q == S_CHECK);
    assign probe_addr     = probe_addr_q;
    assign done           = done_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign fail_pulse     = fail_pulse_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_got = ff_got_q;

endmodule

// File: tb/tb_probe_checker.sv
// Bench for probe_checker: two instances (LAT=1/SETTLE=10 and LAT=3/SETTLE=0) share stimulus,
// each probing a delayed-response memory model; results are compared against a table-level model.
module tb_probe_checker;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int IW = 3;
    localparam int CW = 4;
    localparam int SETTLE_A = 10;
    localparam int LAT_A = 1;
    localparam int SETTLE_B = 0;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst, ld_en, start;
    logic [IW-1:0] ld_idx;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_exp;
    logic [CW-1:0] num;

    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];
    logic          busy   [2];
    logic          done   [2];
    logic          fp     [2];
    logic [CW-1:0] pass_c [2];
    logic [CW-1:0] fail_c [2];
    logic [IW-1:0] ffi    [2];
    logic [DW-1:0] ffg    [2];

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] dut_mem [256];
    logic [AW-1:0] tbl_addr [DEPTH];
    logic [DW-1:0] tbl_exp  [DEPTH];
    int            dly [2];
    logic [DW-1:0] pipe [2][8];
    int            fp_cnt [2] = '{0, 0};
    int            busy_cyc [2] = '{0, 0};

    int            m_pass, m_fail, m_ffi;
    logic [DW-1:0] m_ffg;

    always #5 clk = ~clk;

    probe_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .SETTLE(SETTLE_A), .LAT(LAT_A)) u_a (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr), .ld_exp(ld_exp),
        .start(start), .num(num), .probe_addr(p_addr[0]), .probe_data(p_data[0]), .busy(busy[0]),
        .done(done[0]), .pass_cnt(pass_c[0]), .fail_cnt(fail_c[0]), .fail_pulse(fp[0]),
        .first_fail_idx(ffi[0]), .first_fail_got(ffg[0])
    );

    probe_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .SETTLE(SETTLE_B), .LAT(LAT_B)) u_b (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr), .ld_exp(ld_exp),
        .start(start), .num(num), .probe_addr(p_addr[1]), .probe_data(p_data[1]), .busy(busy[1]),
        .done(done[1]), .pass_cnt(pass_c[1]), .fail_cnt(fail_c[1]), .fail_pulse(fp[1]),
        .first_fail_idx(ffi[1]), .first_fail_got(ffg[1])
    );

    // Debug-port model: memory lookup followed by a dly-deep register pipeline.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 7; i > 0; i--) pipe[d][i] <= pipe[d][i-1];
            pipe[d][0] <= dut_mem[p_addr[d]];
        end
    end
    assign p_data[0] = pipe[0][dly[0]-1];
    assign p_data[1] = pipe[1][dly[1]-1];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (fp[d] === 1'b1) fp_cnt[d]++;
            if (busy[d] === 1'b1) busy_cyc[d]++;
        end
    end

    // Expected outcome of a run over the first n table entries with a correctly timed port.
    task automatic model_run(input int n);
        int nn;
        logic [DW-1:0] got;
        nn = (n > DEPTH) ? DEPTH : n;
        m_pass = 0; m_fail = 0; m_ffi = 0; m_ffg = '0;
        for (int k = 0; k < nn; k++) begin
            got = dut_mem[tbl_addr[k]];
            if (got == tbl_exp[k]) m_pass++;
            else begin
                if (m_fail == 0) begin m_ffi = k; m_ffg = got; end
                m_fail++;
            end
        end
    endtask

    function automatic int run_cycles(input int d, input int n);
        int nn;
        nn = (n > DEPTH) ? DEPTH : n;
        if (nn == 0) return 0;
        if (d == 0) return ((SETTLE_A > 0) ? SETTLE_A : 1) + nn * (LAT_A + 2);
        return ((SETTLE_B > 0) ? SETTLE_B : 1) + nn * (LAT_B + 2);
    endfunction

    task automatic load_entry(input int i, input logic [AW-1:0] a, input logic [DW-1:0] e);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = IW'(i); ld_addr = a; ld_exp = e;
        @(negedge clk);
        ld_en = 1'b0;
        tbl_addr[i] = a; tbl_exp[i] = e;
    endtask

    task automatic kick(input int n);
        @(negedge clk);
        start = 1'b1; num = CW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!(done[0] === 1'b1 && done[1] === 1'b1) && c < 2000) begin
            @(negedge clk); c++;
        end
        checks++;
        if (!(done[0] === 1'b1 && done[1] === 1'b1)) begin
            errors++;
            $display("FAIL %s_timeout done=%b%b required 11", tag, done[0], done[1]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (p_addr[d] !== '0) begin errors++; $display("FAIL reset_probe_addr dut%0d got %0h exp 0", d, p_addr[d]); end
            checks++;
            if ({busy[d], done[d], fp[d]} !== 3'b000) begin errors++; $display("FAIL reset_flags dut%0d busy/done/pulse got %b%b%b exp 000", d, busy[d], done[d], fp[d]); end
            checks++;
            if ({pass_c[d], fail_c[d]} !== '0) begin errors++; $display("FAIL reset_counters dut%0d got pass %0d fail %0d exp 0 0", d, pass_c[d], fail_c[d]); end
            checks++;
            if (ffi[d] !== '0 || ffg[d] !== '0) begin errors++; $display("FAIL reset_first_fail dut%0d got idx %0d data %0h exp 0 0", d, ffi[d], ffg[d]); end
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_directed();
        int fp0 [2];
        int bc0 [2];
        dut_mem[8'h04] = 32'd5; dut_mem[8'h08] = 32'd8; dut_mem[8'h0C] = 32'd13;
        load_entry(0, 8'h04, 32'd5);
        load_entry(1, 8'h08, 32'd8);
        load_entry(2, 8'h0C, 32'd13);
        fp0 = fp_cnt; bc0 = busy_cyc;
        kick(3);
        wait_done("directed_pass");
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pass_c[d] !== 4'd3 || fail_c[d] !== 4'd0) begin errors++; $display("FAIL directed_pass_counts dut%0d got pass %0d fail %0d exp 3 0", d, pass_c[d], fail_c[d]); end
            checks++;
            if (fp_cnt[d] - fp0[d] != 0) begin errors++; $display("FAIL directed_pass_pulses dut%0d got %0d exp 0", d, fp_cnt[d] - fp0[d]); end
            checks++;
            if (busy_cyc[d] - bc0[d] != run_cycles(d, 3)) begin errors++; $display("FAIL directed_busy_cycles dut%0d got %0d exp %0d", d, busy_cyc[d] - bc0[d], run_cycles(d, 3)); end
            checks++;
            if (p_addr[d] !== 8'h0C) begin errors++; $display("FAIL directed_addr_hold dut%0d got %0h exp 0c", d, p_addr[d]); end
        end
        $display("directed run 1: pass %0d/%0d fail %0d/%0d", pass_c[0], pass_c[1], fail_c[0], fail_c[1]);
        load_entry(1, 8'h08, 32'd9);
        fp0 = fp_cnt;
        kick(3);
        wait_done("directed_fail");
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pass_c[d] !== 4'd2 || fail_c[d] !== 4'd1) begin errors++; $display("FAIL directed_fail_counts dut%0d got pass %0d fail %0d exp 2 1", d, pass_c[d], fail_c[d]); end
            checks++;
            if (ffi[d] !== 3'd1 || ffg[d] !== 32'd8) begin errors++; $display("FAIL directed_first_fail dut%0d got idx %0d data %0d exp 1 8", d, ffi[d], ffg[d]); end
            checks++;
            if (fp_cnt[d] - fp0[d] != 1) begin errors++; $display("FAIL directed_fail_pulses dut%0d got %0d exp 1", d, fp_cnt[d] - fp0[d]); end
        end
        $display("directed run 2: pass %0d/%0d fail %0d/%0d", pass_c[0], pass_c[1], fail_c[0], fail_c[1]);
    endtask

    task automatic test_random(input int iters, input int force_n);
        int n;
        int fp0 [2];
        int bc0 [2];
        logic [AW-1:0] a;
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < 256; i++) dut_mem[i] = $urandom;
            n = (force_n > 0) ? force_n : $urandom_range(1, DEPTH);
            for (int k = 0; k < DEPTH; k++) begin
                a = AW'($urandom_range(0, 255));
                if ($urandom_range(0, 2) == 0) load_entry(k, a, dut_mem[a] ^ (32'd1 << $urandom_range(0, 31)));
                else load_entry(k, a, dut_mem[a]);
            end
            model_run(n);
            fp0 = fp_cnt; bc0 = busy_cyc;
            kick(n);
            wait_done("random");
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (pass_c[d] !== CW'(m_pass) || fail_c[d] !== CW'(m_fail)) begin errors++; $display("FAIL random_counts dut%0d n=%0d got pass %0d fail %0d exp %0d %0d", d, n, pass_c[d], fail_c[d], m_pass, m_fail); end
                checks++;
                if (ffi[d] !== IW'(m_ffi) || ffg[d] !== m_ffg) begin errors++; $display("FAIL random_first_fail dut%0d got idx %0d data %0h exp %0d %0h", d, ffi[d], ffg[d], m_ffi, m_ffg); end
                checks++;
                if (fp_cnt[d] - fp0[d] != m_fail) begin errors++; $display("FAIL random_pulses dut%0d got %0d exp %0d", d, fp_cnt[d] - fp0[d], m_fail); end
                checks++;
                if (busy_cyc[d] - bc0[d] != run_cycles(d, n)) begin errors++; $display("FAIL random_busy_cycles dut%0d got %0d exp %0d", d, busy_cyc[d] - bc0[d], run_cycles(d, n)); end
            end
            $display("random run n=%0d: model pass %0d fail %0d, dut pass %0d/%0d fail %0d/%0d", n, m_pass, m_fail, pass_c[0], pass_c[1], fail_c[0], fail_c[1]);
        end
    endtask

    task automatic test_latency();
        logic [AW-1:0] base;
        int fp0;
        for (int i = 0; i < 256; i++) dut_mem[i] = 32'h5A5A_0000 | i;
        base = p_addr[1] + 8'h10;
        for (int k = 0; k < 4; k++) load_entry(k, base + AW'(4 * k), dut_mem[base + AW'(4 * k)]);
        kick(4);
        wait_done("lat_match");
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pass_c[d] !== 4'd4 || fail_c[d] !== 4'd0) begin errors++; $display("FAIL lat_match_counts dut%0d got pass %0d fail %0d exp 4 0", d, pass_c[d], fail_c[d]); end
        end
        $display("latency matched: dut1 pass %0d fail %0d", pass_c[1], fail_c[1]);
        dly[1] = 4;
        fp0 = fp_cnt[1];
        kick(4);
        wait_done("lat_slow");
        checks++;
        if (pass_c[1] !== 4'd0 || fail_c[1] !== 4'd4) begin errors++; $display("FAIL lat_slow_counts got pass %0d fail %0d exp 0 4", pass_c[1], fail_c[1]); end
        checks++;
        if (fp_cnt[1] - fp0 != 4) begin errors++; $display("FAIL lat_slow_pulses got %0d exp 4", fp_cnt[1] - fp0); end
        checks++;
        if (pass_c[0] !== 4'd4) begin errors++; $display("FAIL lat_slow_other_dut got pass %0d exp 4", pass_c[0]); end
        $display("latency slow port: dut1 pass %0d fail %0d", pass_c[1], fail_c[1]);
        dly[1] = LAT_B;
    endtask

    task automatic test_num_zero();
        logic [AW-1:0] prev [2];
        int bc0 [2];
        prev = p_addr; bc0 = busy_cyc;
        kick(0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (done[d] !== 1'b1) begin errors++; $display("FAIL num_zero_done dut%0d got %b exp 1", d, done[d]); end
            checks++;
            if (pass_c[d] !== '0 || fail_c[d] !== '0) begin errors++; $display("FAIL num_zero_counts dut%0d got pass %0d fail %0d exp 0 0", d, pass_c[d], fail_c[d]); end
            checks++;
            if (p_addr[d] !== prev[d] || busy_cyc[d] != bc0[d]) begin errors++; $display("FAIL num_zero_quiet dut%0d got addr %0h busy cycles %0d exp %0h 0", d, p_addr[d], busy_cyc[d] - bc0[d], prev[d]); end
        end
        $display("num zero: done %b/%b", done[0], done[1]);
    endtask

    task automatic test_reset_midrun();
        bit found;
        for (int k = 0; k < 4; k++) load_entry(k, AW'(8'h40 + 4 * k), dut_mem[8'h40 + 4 * k]);
        kick(4);
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (busy[0] === 1'b1 && pass_c[0] === 4'd2 && p_addr[0] === tbl_addr[2]) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midrun_reach_entry2 got not reached exp reached"); end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d]} !== 2'b00 || pass_c[d] !== '0 || fail_c[d] !== '0) begin
                errors++;
                $display("FAIL midrun_reset dut%0d got busy %b done %b pass %0d fail %0d exp 0 0 0 0", d, busy[d], done[d], pass_c[d], fail_c[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_run(4);
        kick(4);
        wait_done("midrun_rerun");
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pass_c[d] !== CW'(m_pass) || fail_c[d] !== CW'(m_fail)) begin errors++; $display("FAIL midrun_rerun dut%0d got pass %0d fail %0d exp %0d %0d", d, pass_c[d], fail_c[d], m_pass, m_fail); end
        end
        $display("reset mid-run then rerun: pass %0d/%0d", pass_c[0], pass_c[1]);
    endtask

    task automatic test_busy_ignore();
        int bc0 [2];
        for (int k = 0; k < 5; k++) load_entry(k, AW'(8'h80 + k), dut_mem[8'h80 + k]);
        model_run(5);
        bc0 = busy_cyc;
        kick(5);
        repeat (7) @(negedge clk);
        start = 1'b1; num = CW'(2);
        ld_en = 1'b1; ld_idx = IW'(4); ld_addr = tbl_addr[4] ^ 8'hFF; ld_exp = ~tbl_exp[4];
        @(negedge clk);
        start = 1'b0; ld_en = 1'b0;
        wait_done("busy_ignore");
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pass_c[d] !== CW'(m_pass) || fail_c[d] !== CW'(m_fail)) begin errors++; $display("FAIL busy_ignore_counts dut%0d got pass %0d fail %0d exp %0d %0d", d, pass_c[d], fail_c[d], m_pass, m_fail); end
            checks++;
            if (busy_cyc[d] - bc0[d] != run_cycles(d, 5)) begin errors++; $display("FAIL busy_ignore_cycles dut%0d got %0d exp %0d", d, busy_cyc[d] - bc0[d], run_cycles(d, 5)); end
        end
        kick(5);
        wait_done("busy_ignore_table");
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (pass_c[d] !== CW'(m_pass) || fail_c[d] !== CW'(m_fail)) begin errors++; $display("FAIL busy_ignore_table dut%0d got pass %0d fail %0d exp %0d %0d", d, pass_c[d], fail_c[d], m_pass, m_fail); end
        end
        $display("start/load while busy: pass %0d/%0d fail %0d/%0d", pass_c[0], pass_c[1], fail_c[0], fail_c[1]);
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; start = 1'b0; ld_idx = '0; ld_addr = '0; ld_exp = '0; num = '0;
        dly[0] = LAT_A; dly[1] = LAT_B;
        for (int i = 0; i < 256; i++) dut_mem[i] = $urandom;
        test_reset();
        test_directed();
        test_random(6, 0);
        test_latency();
        test_num_zero();
        test_random(1, 15);
        test_reset_midrun();
        test_busy_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
